seg7_frame_decoder: RTL and testbench
=====================================

SEG7_FRAME_DECODER -- requirements
Module: seg7_frame_decoder

Interface
REQ-001 Parameter: TIMEOUT, default 255, max idle cycles between digit strobes inside a frame; legal range 1..65535.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-low reset; sampled on rising clk edge.
REQ-004 seg_in  input  7  active-low segment pattern, bit0=a .. bit6=g.
REQ-005 dig_sel  input  6  one-hot digit select; bit k = digit k, digit 0 least significant.
REQ-006 seg_valid  input  1  seg_in/dig_sel qualified this cycle.
REQ-007 value  output  24  last complete frame, 4 bits per digit, digit k at value[4k+3:4k].
REQ-008 frame_valid  output  1  one-cycle pulse, value just updated.
REQ-009 pat_err  output  1  one-cycle pulse, undecodable pattern in frame.
REQ-010 seq_err  output  1  one-cycle pulse, out-of-order or non-one-hot dig_sel in frame.
REQ-011 tmo_err  output  1  one-cycle pulse, frame aborted by timeout.

Function
REQ-012 Decode table (seg_in -> nibble): 1000000->0, 1111001->1, 0100100->2, 0110000->3, 0011001->4, 0010010->5, 0000010->6, 1111000->7, 0000000->8, 0010000->9, 0001000->A, 0000011->b, 1000110->C, 0100001->d, 0000110->E, 0001110->F; all other 112 patterns undecodable.
REQ-013 FSM states: IDLE, COLLECT; internal digit index idx (0..5), 24-bit assembly buffer, timeout counter.
REQ-014 All outputs registered; every response appears in the cycle after the strobe edge that caused it.
REQ-015 IDLE: strobe (seg_valid=1) with dig_sel=000001 and decodable pattern -> store nibble 0, idx=1, go COLLECT.
REQ-016 IDLE: any other strobe ignored, no error pulse; no strobe -> stay IDLE.
REQ-017 COLLECT: strobe with dig_sel = one-hot(idx) and decodable pattern -> store nibble idx, idx+1, timeout counter cleared.
REQ-018 COLLECT: accepted strobe at idx=5 -> value <= buffer incl. digit 5, frame_valid=1 next cycle, go IDLE.
REQ-019 COLLECT: strobe with dig_sel=000001 and decodable pattern -> frame restart: seq_err pulse, buffer cleared, nibble 0 stored, idx=1, stay COLLECT.
REQ-020 COLLECT: strobe with any other dig_sel (wrong digit, zero, multi-hot) -> seq_err pulse, buffer discarded, go IDLE.
REQ-021 Undecodable pattern on any strobe in COLLECT, or on digit-0 strobe in IDLE -> pat_err pulse, buffer discarded, go/stay IDLE; pat_err takes priority, seq_err not raised same cycle.
REQ-022 COLLECT: counter increments each cycle without seg_valid; reaching TIMEOUT -> tmo_err pulse, buffer discarded, go IDLE.
REQ-023 Strobe in the same cycle the counter would reach TIMEOUT is processed normally; no tmo_err.
REQ-024 value changes only on frame completion; holds across errors, restarts, aborts.
REQ-025 At most one of frame_valid, pat_err, seq_err, tmo_err high in any cycle.
REQ-026 Counter width 16 bits; no wrap inside COLLECT (abort precedes overflow).

Reset
REQ-027 reset=0 at a rising edge -> state IDLE, idx=0, buffer=0, counter=0, value=0, frame_valid=pat_err=seq_err=tmo_err=0 next cycle.
REQ-028 Reset mid-frame discards partial frame; no error pulse generated; reset overrides all other inputs.

Verification
REQ-029 Six strobes, digits 0..5, patterns for 1,2,3,4,5,E (1111001,0100100,0110000,0011001,0010010,0000110), gaps 0..3 cycles -> value=0xE54321, one frame_valid pulse, no errors.
REQ-030 Digits 0,1 then dig_sel=001000 -> seq_err one cycle, value unchanged; next full frame 0..5 all 0000000 -> value=0x888888.
REQ-031 Digit 2 strobe seg_in=1111111 mid-frame -> pat_err only (no seq_err), IDLE; strobe digit 3 afterward ignored silently.
REQ-032 TIMEOUT=4: digit 0 then no strobe -> tmo_err exactly 4 cycles after the digit-0 edge; strobe at cycle 4 instead -> accepted, no tmo_err.
REQ-033 Digits 0..3 then reset=0 one cycle -> all outputs 0, no pulses; digits 4,5 afterward ignored; fresh 0..5 frame completes normally.
REQ-034 Digits 0,1,2 then digit 0 again (pattern 0001000) then 1..5 -> one seq_err at restart, then frame_valid with value[3:0]=0xA.

Source files
------------

// File: rtl/seg7_frame_decoder.sv
// Seven-segment scan decoder: reassembles six strobed digits
// into a 24-bit hex frame with sequence, pattern and timeout checks.
module seg7_frame_decoder #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [6:0]  seg_in,
  input  logic [5:0]  dig_sel,
  input  logic        seg_valid,
  output logic [23:0] value,
  output logic        frame_valid,
  output logic        pat_err,
  output logic        seq_err,
  output logic        tmo_err
);

  typedef enum logic {
    IDLE,
    COLLECT
  } state_t;

  localparam logic [15:0] TMO = 16'(TIMEOUT);

  state_t      state, nstate;
  logic [2:0]  idx, nidx;
  logic [23:0] asm_q, nasm;
  logic [15:0] cnt, ncnt;
  logic [23:0] nvalue;
  logic        nfv, npat, nseq, ntmo;

  logic        dec_ok;
  logic [3:0]  nib;
  logic [5:0]  exp_sel;
  logic        sel_hit;
  logic        sel_d0;

  always_comb begin
    dec_ok = 1'b1;
    nib    = 4'h0;
    case (seg_in)
      7'b1000000: nib = 4'h0;
      7'b1111001: nib = 4'h1;
      7'b0100100: nib = 4'h2;
      7'b0110000: nib = 4'h3;
      7'b0011001: nib = 4'h4;
      7'b0010010: nib = 4'h5;
      7'b0000010: nib = 4'h6;
      7'b1111000: nib = 4'h7;
      7'b0000000: nib = 4'h8;
      7'b0010000: nib = 4'h9;
      7'b0001000: nib = 4'hA;
      7'b0000011: nib = 4'hB;
      7'b1000110: nib = 4'hC;
      7'b0100001: nib = 4'hD;
      7'b0000110: nib = 4'hE;
      7'b0001110: nib = 4'hF;
      default:    dec_ok = 1'b0;
    endcase
  end

  assign exp_sel = 6'(6'b000001 << idx);
  assign sel_hit = (dig_sel == exp_sel);
  assign sel_d0  = (dig_sel == 6'b000001);

  always_comb begin
    nstate = state;
    nidx   = idx;
    nasm   = asm_q;
    ncnt   = cnt;
    nvalue = value;
    nfv    = 1'b0;
    npat   = 1'b0;
    nseq   = 1'b0;
    ntmo   = 1'b0;
    unique case (state)
      IDLE: begin
        if (seg_valid && sel_d0) begin
          if (dec_ok) begin
            nasm   = {20'h0, nib};
            nidx   = 3'd1;
            ncnt   = 16'h0;
            nstate = COLLECT;
          end else begin
            npat = 1'b1;
          end
        end
      end
      COLLECT: begin
        if (seg_valid) begin
          if (!dec_ok) begin
            npat   = 1'b1;
            nstate = IDLE;
            nasm   = 24'h0;
            nidx   = 3'd0;
            ncnt   = 16'h0;
          end else if (sel_hit) begin
            ncnt = 16'h0;
            for (int k = 0; k < 6; k++) begin
              if (idx == 3'(k)) nasm[4*k +: 4] = nib;
            end
            if (idx == 3'd5) begin
              nvalue = nasm;
              nfv    = 1'b1;
              nstate = IDLE;
              nasm   = 24'h0;
              nidx   = 3'd0;
            end else begin
              nidx = idx + 3'd1;
            end
          end else if (sel_d0) begin
            // digit 0 mid-frame restarts collection
            nseq = 1'b1;
            nasm = {20'h0, nib};
            nidx = 3'd1;
            ncnt = 16'h0;
          end else begin
            nseq   = 1'b1;
            nstate = IDLE;
            nasm   = 24'h0;
            nidx   = 3'd0;
            ncnt   = 16'h0;
          end
        end else if (cnt + 16'd1 == TMO) begin
          ntmo   = 1'b1;
          nstate = IDLE;
          nasm   = 24'h0;
          nidx   = 3'd0;
          ncnt   = 16'h0;
        end else begin
          ncnt = cnt + 16'd1;
        end
      end
      default: nstate = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= IDLE;
      idx         <= 3'd0;
      asm_q       <= 24'h0;
      cnt         <= 16'h0;
      value       <= 24'h0;
      frame_valid <= 1'b0;
      pat_err     <= 1'b0;
      seq_err     <= 1'b0;
      tmo_err     <= 1'b0;
    end else begin
      state       <= nstate;
      idx         <= nidx;
      asm_q       <= nasm;
      cnt         <= ncnt;
      value       <= nvalue;
      frame_valid <= nfv;
      pat_err     <= npat;
      seq_err     <= nseq;
      tmo_err     <= ntmo;
    end
  end

endmodule

// File: tb/tb_seg7_frame_decoder.sv
// Directed bench for seg7_frame_decoder with TIMEOUT=4.
// Scenario tasks drive strobes and compare hand-computed results.
module tb_seg7_frame_decoder;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [6:0]  seg_in = 7'h7f;
  logic [5:0]  dig_sel = 6'h0;
  logic        seg_valid = 1'b0;
  logic [23:0] value;
  logic        frame_valid;
  logic        pat_err;
  logic        seq_err;
  logic        tmo_err;

  int asserts = 0;
  int failures = 0;
  int n_fv = 0;
  int n_pat = 0;
  int n_seq = 0;
  int n_tmo = 0;

  seg7_frame_decoder #(.TIMEOUT(4)) dut (
    .clk(clk),
    .reset(reset),
    .seg_in(seg_in),
    .dig_sel(dig_sel),
    .seg_valid(seg_valid),
    .value(value),
    .frame_valid(frame_valid),
    .pat_err(pat_err),
    .seq_err(seq_err),
    .tmo_err(tmo_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (frame_valid) n_fv++;
    if (pat_err) n_pat++;
    if (seq_err) n_seq++;
    if (tmo_err) n_tmo++;
  end

  function automatic logic [6:0] pat(input logic [3:0] n);
    case (n)
      4'h0: pat = 7'b1000000;
      4'h1: pat = 7'b1111001;
      4'h2: pat = 7'b0100100;
      4'h3: pat = 7'b0110000;
      4'h4: pat = 7'b0011001;
      4'h5: pat = 7'b0010010;
      4'h6: pat = 7'b0000010;
      4'h7: pat = 7'b1111000;
      4'h8: pat = 7'b0000000;
      4'h9: pat = 7'b0010000;
      4'hA: pat = 7'b0001000;
      4'hB: pat = 7'b0000011;
      4'hC: pat = 7'b1000110;
      4'hD: pat = 7'b0100001;
      4'hE: pat = 7'b0000110;
      default: pat = 7'b0001110;
    endcase
  endfunction

  task automatic strobe(input logic [5:0] d,
                        input logic [6:0] s);
    seg_valid = 1'b1;
    dig_sel = d;
    seg_in = s;
    @(posedge clk);
    #1;
    seg_valid = 1'b0;
    dig_sel = 6'h0;
    seg_in = 7'h7f;
  endtask

  task automatic gap(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic digit(input int k, input logic [3:0] n);
    strobe(6'(1 << k), pat(n));
  endtask

  task automatic send_frame(input logic [23:0] v);
    for (int k = 0; k < 6; k++) digit(k, v[4*k +: 4]);
  endtask

  task automatic test_reset;
    reset = 1'b0;
    gap(2);
    asserts++;
    if (value !== 24'h0) begin
      failures++;
      $display("FAIL reset_value got %h want 000000", value);
    end
    asserts++;
    if ({frame_valid, pat_err, seq_err, tmo_err} !== 4'b0) begin
      failures++;
      $display("FAIL reset_pulses got %b want 0000",
               {frame_valid, pat_err, seq_err, tmo_err});
    end
    reset = 1'b1;
    gap(1);
  endtask

  task automatic test_frame;
    int f0, e0;
    f0 = n_fv;
    e0 = n_pat + n_seq + n_tmo;
    digit(0, 4'h1);
    digit(1, 4'h2);
    gap(1);
    digit(2, 4'h3);
    gap(2);
    digit(3, 4'h4);
    gap(3);
    digit(4, 4'h5);
    asserts++;
    if (value !== 24'h0 || frame_valid !== 1'b0) begin
      failures++;
      $display("FAIL frame_partial got %h/%b want 000000/0",
               value, frame_valid);
    end
    digit(5, 4'hE);
    asserts++;
    if (frame_valid !== 1'b1 || value !== 24'hE54321) begin
      failures++;
      $display("FAIL frame_done got %h/%b want e54321/1",
               value, frame_valid);
    end
    gap(1);
    asserts++;
    if (frame_valid !== 1'b0) begin
      failures++;
      $display("FAIL frame_pulse_len got %b want 0", frame_valid);
    end
    gap(1);
    asserts++;
    if (n_fv - f0 != 1 || n_pat + n_seq + n_tmo - e0 != 0) begin
      failures++;
      $display("FAIL frame_counts got fv=%0d err=%0d want 1/0",
               n_fv - f0, n_pat + n_seq + n_tmo - e0);
    end
  endtask

  task automatic test_seq;
    int s0;
    s0 = n_seq;
    digit(0, 4'h1);
    digit(1, 4'h2);
    strobe(6'b001000, pat(4'h3));
    asserts++;
    if (seq_err !== 1'b1 || pat_err !== 1'b0 ||
        value !== 24'hE54321) begin
      failures++;
      $display("FAIL seq_err got seq=%b pat=%b v=%h want 1/0/e54321",
               seq_err, pat_err, value);
    end
    gap(1);
    asserts++;
    if (seq_err !== 1'b0) begin
      failures++;
      $display("FAIL seq_pulse_len got %b want 0", seq_err);
    end
    send_frame(24'h888888);
    asserts++;
    if (frame_valid !== 1'b1 || value !== 24'h888888) begin
      failures++;
      $display("FAIL seq_next_frame got %h/%b want 888888/1",
               value, frame_valid);
    end
    gap(2);
    asserts++;
    if (n_seq - s0 != 1) begin
      failures++;
      $display("FAIL seq_count got %0d want 1", n_seq - s0);
    end
  endtask

  task automatic test_pat;
    int p0, s0, f0, t0;
    p0 = n_pat;
    s0 = n_seq;
    f0 = n_fv;
    t0 = n_tmo;
    digit(0, 4'h1);
    digit(1, 4'h2);
    strobe(6'b000100, 7'b1111111);
    asserts++;
    if (pat_err !== 1'b1 || seq_err !== 1'b0) begin
      failures++;
      $display("FAIL pat_mid got pat=%b seq=%b want 1/0",
               pat_err, seq_err);
    end
    gap(1);
    digit(3, 4'h4);
    gap(2);
    asserts++;
    if (n_pat - p0 != 1 || n_seq - s0 != 0 ||
        n_fv - f0 != 0 || n_tmo - t0 != 0) begin
      failures++;
      $display("FAIL pat_counts got p=%0d s=%0d f=%0d t=%0d want 1/0/0/0",
               n_pat - p0, n_seq - s0, n_fv - f0, n_tmo - t0);
    end
    strobe(6'b000001, 7'b1010101);
    asserts++;
    if (pat_err !== 1'b1 || value !== 24'h888888) begin
      failures++;
      $display("FAIL pat_idle_d0 got pat=%b v=%h want 1/888888",
               pat_err, value);
    end
    gap(2);
  endtask

  task automatic test_timeout;
    int t0;
    t0 = n_tmo;
    digit(0, 4'h6);
    gap(3);
    asserts++;
    if (tmo_err !== 1'b0) begin
      failures++;
      $display("FAIL tmo_early got %b want 0", tmo_err);
    end
    gap(1);
    asserts++;
    if (tmo_err !== 1'b1) begin
      failures++;
      $display("FAIL tmo_fire got %b want 1", tmo_err);
    end
    gap(1);
    digit(0, 4'h6);
    gap(3);
    digit(1, 4'h7);
    asserts++;
    if (tmo_err !== 1'b0) begin
      failures++;
      $display("FAIL tmo_edge_strobe got %b want 0", tmo_err);
    end
    digit(2, 4'h9);
    digit(3, 4'hA);
    digit(4, 4'hB);
    digit(5, 4'hC);
    asserts++;
    if (frame_valid !== 1'b1 || value !== 24'hCBA976) begin
      failures++;
      $display("FAIL tmo_frame got %h/%b want cba976/1",
               value, frame_valid);
    end
    gap(2);
    asserts++;
    if (n_tmo - t0 != 1) begin
      failures++;
      $display("FAIL tmo_count got %0d want 1", n_tmo - t0);
    end
  endtask

  task automatic test_reset_mid;
    int c0;
    c0 = n_fv + n_pat + n_seq + n_tmo;
    for (int k = 0; k < 4; k++) digit(k, 4'h1);
    reset = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    asserts++;
    if (value !== 24'h0 ||
        {frame_valid, pat_err, seq_err, tmo_err} !== 4'b0) begin
      failures++;
      $display("FAIL rst_mid got v=%h p=%b want 000000/0000", value,
               {frame_valid, pat_err, seq_err, tmo_err});
    end
    digit(4, 4'h5);
    digit(5, 4'h5);
    gap(2);
    asserts++;
    if (value !== 24'h0 || n_fv + n_pat + n_seq + n_tmo != c0) begin
      failures++;
      $display("FAIL rst_tail got v=%h pulses=%0d want 000000/0",
               value, n_fv + n_pat + n_seq + n_tmo - c0);
    end
    send_frame(24'h210FED);
    asserts++;
    if (frame_valid !== 1'b1 || value !== 24'h210FED) begin
      failures++;
      $display("FAIL rst_fresh got %h/%b want 210fed/1",
               value, frame_valid);
    end
    gap(1);
  endtask

  task automatic test_restart;
    int s0;
    s0 = n_seq;
    digit(0, 4'h1);
    digit(1, 4'h2);
    digit(2, 4'h3);
    digit(0, 4'hA);
    asserts++;
    if (seq_err !== 1'b1) begin
      failures++;
      $display("FAIL restart_seq got %b want 1", seq_err);
    end
    for (int k = 1; k < 6; k++) digit(k, 4'(k));
    asserts++;
    if (frame_valid !== 1'b1 || value !== 24'h54321A) begin
      failures++;
      $display("FAIL restart_frame got %h/%b want 54321a/1",
               value, frame_valid);
    end
    gap(2);
    asserts++;
    if (n_seq - s0 != 1) begin
      failures++;
      $display("FAIL restart_count got %0d want 1", n_seq - s0);
    end
  endtask

  task automatic test_back_to_back;
    int f0;
    f0 = n_fv;
    send_frame(24'h999999);
    asserts++;
    if (frame_valid !== 1'b1 || value !== 24'h999999) begin
      failures++;
      $display("FAIL b2b_first got %h/%b want 999999/1",
               value, frame_valid);
    end
    send_frame(24'h7B7C7D);
    asserts++;
    if (frame_valid !== 1'b1 || value !== 24'h7B7C7D) begin
      failures++;
      $display("FAIL b2b_second got %h/%b want 7b7c7d/1",
               value, frame_valid);
    end
    gap(2);
    asserts++;
    if (n_fv - f0 != 2) begin
      failures++;
      $display("FAIL b2b_count got %0d want 2", n_fv - f0);
    end
  endtask

  initial begin
    test_reset;
    test_frame;
    test_seq;
    test_pat;
    test_timeout;
    test_reset_mid;
    test_restart;
    test_back_to_back;
    $display("End of test - %0d assertions evaluated, %0d failures",
             asserts, failures);
    $finish;
  end

endmodule
